// File: rtl/data_mem_responder.sv
// Byte-addressed data memory with four little-endian byte lanes and a one-cycle registered read.
// Optional output register at MMIO_ADDR is built only when DMEM_MMIO_EN is defined.
module data_mem_responder #(
  parameter int          AW        = 10,
  parameter logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [31:0]      mem_addr,
  input  logic             mem_write_en,
  input  logic [0:3][7:0]  mem_data_in,
  output logic [0:3][7:0]  mem_data_out,
  output logic             oor_err,
  output logic [15:0]      wr_count
`ifdef DMEM_MMIO_EN
  ,
  output logic [31:0]      mmio_out
`endif
);

  localparam int DEPTH = 2 ** AW;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   idx [4];
  logic            in_range;
  logic            mmio_match;
  logic            mmio_hit;
  logic            mem_hit;
  logic [0:3][7:0] mmio_lanes;
  logic [0:3][7:0] data_next;

  assign in_range   = (mem_addr[31:AW] == '0);
  assign mmio_match = (mem_addr == MMIO_ADDR);
  assign mem_hit    = in_range && !mmio_match;

`ifdef DMEM_MMIO_EN
  assign mmio_hit   = mmio_match;
  assign mmio_lanes = {mmio_out[7:0], mmio_out[15:8], mmio_out[23:16], mmio_out[31:24]};
`else
  assign mmio_hit   = 1'b0;
  assign mmio_lanes = '0;
`endif

  // Lane indices wrap within the storage; the carry out of AW bits is dropped.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      idx[i] = mem_addr[AW-1:0] + AW'(i);
    end
  end

  // A write and a read always touch the same four bytes, so write-first reduces to forwarding the lanes.
  always_comb begin
    data_next = '0;
    if (mmio_hit) begin
      data_next = mem_write_en ? mem_data_in : mmio_lanes;
    end else if (mem_hit) begin
      for (int i = 0; i < 4; i++) begin
        data_next[i] = mem_write_en ? mem_data_in[i] : mem[idx[i]];
      end
    end
  end

  // Storage keeps its contents through reset; a write is only lost when reset is low at the edge.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
    end else if (mem_write_en && mem_hit) begin
      for (int i = 0; i < 4; i++) begin
        mem[idx[i]] <= mem_data_in[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mem_data_out <= '0;
      oor_err      <= 1'b0;
      wr_count     <= '0;
    end else begin
      mem_data_out <= data_next;
      if (!mem_hit && !mmio_hit) begin
        oor_err <= 1'b1;
      end
      if (mem_write_en && (mem_hit || mmio_hit)) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

`ifdef DMEM_MMIO_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mmio_out <= '0;
    end else if (mmio_hit && mem_write_en) begin
      mmio_out <= {mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]};
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed-vector bench for data_mem_responder; lane words are written as {lane0,lane1,lane2,lane3}.
module tb_data_mem_responder;

  logic            clk;
  logic            rst_b;
  logic [31:0]     mem_addr;
  logic            mem_write_en;
  logic [0:3][7:0] mem_data_in;
  logic [0:3][7:0] mem_data_out;
  logic            oor_err;
  logic [15:0]     wr_count;
`ifdef DMEM_MMIO_EN
  logic [31:0]     mmio_out;
`endif

  int vec_count;
  int err_count;

  data_mem_responder dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .mem_addr     (mem_addr),
    .mem_write_en (mem_write_en),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .oor_err      (oor_err),
    .wr_count     (wr_count)
`ifdef DMEM_MMIO_EN
    ,
    .mmio_out     (mmio_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
    end
  endtask

  // Present one access for a single cycle; outputs are settled 1 time unit after the edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [31:0] lanes);
    mem_addr     = addr;
    mem_write_en = we;
    mem_data_in  = lanes;
    @(posedge clk);
    #1;
    mem_write_en = 1'b0;
  endtask

  task automatic pulseReset();
    #2 rst_b = 1'b0;
    #2 rst_b = 1'b1;
  endtask

  initial begin
    vec_count    = 0;
    err_count    = 0;
    rst_b        = 1'b0;
    mem_addr     = '0;
    mem_write_en = 1'b0;
    mem_data_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_data", mem_data_out, 32'h0);
    checkOutput("reset_oor", {31'b0, oor_err}, 32'h0);
    checkOutput("reset_count", {16'b0, wr_count}, 32'h0);
    rst_b = 1'b1;

    applyStimulus(32'h10, 1'b1, 32'h1111_1111);
    checkOutput("prefill_count", {16'b0, wr_count}, 32'd1);

    // Reset lands between the edges of a write cycle: the write must vanish.
    mem_addr     = 32'h10;
    mem_write_en = 1'b1;
    mem_data_in  = 32'h9999_9999;
    #2 rst_b = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_data", mem_data_out, 32'h0);
    checkOutput("midrst_oor", {31'b0, oor_err}, 32'h0);
    checkOutput("midrst_count", {16'b0, wr_count}, 32'h0);
    mem_write_en = 1'b0;
    rst_b        = 1'b1;
    applyStimulus(32'h10, 1'b0, 32'h0);
    checkOutput("midrst_kept", mem_data_out, 32'h1111_1111);
    checkOutput("midrst_count2", {16'b0, wr_count}, 32'h0);

    applyStimulus(32'h10, 1'b1, 32'hEFBE_ADDE);
    checkOutput("wr10_fwd", mem_data_out, 32'hEFBE_ADDE);
    checkOutput("wr10_count", {16'b0, wr_count}, 32'd1);
    applyStimulus(32'h10, 1'b0, 32'h0);
    checkOutput("rd10", mem_data_out, 32'hEFBE_ADDE);

    applyStimulus(32'h20, 1'b1, 32'hAAAA_AAAA);
    applyStimulus(32'h20, 1'b1, 32'h0102_0304);
    checkOutput("wr20_first", mem_data_out, 32'h0102_0304);
    checkOutput("wr20_count", {16'b0, wr_count}, 32'd3);
    applyStimulus(32'h20, 1'b0, 32'h0);
    checkOutput("rd20", mem_data_out, 32'h0102_0304);
    applyStimulus(32'h12, 1'b0, 32'h0);
    checkOutput("rd12_offset", mem_data_out[0:1], 32'h0000_ADDE);

    applyStimulus(32'h000, 1'b1, 32'hA0A1_A2A3);
    applyStimulus(32'h3FF, 1'b1, 32'h1122_3344);
    checkOutput("wrap_count", {16'b0, wr_count}, 32'd5);
    applyStimulus(32'h000, 1'b0, 32'h0);
    checkOutput("wrap_rd0", mem_data_out, 32'h2233_44A3);
    applyStimulus(32'h3FF, 1'b0, 32'h0);
    checkOutput("wrap_rd3ff", mem_data_out, 32'h1122_3344);
    checkOutput("wrap_oor", {31'b0, oor_err}, 32'h0);

    applyStimulus(32'h0000_0400, 1'b1, 32'h5566_7788);
    checkOutput("oor_data", mem_data_out, 32'h0);
    checkOutput("oor_flag", {31'b0, oor_err}, 32'h1);
    checkOutput("oor_count", {16'b0, wr_count}, 32'd5);
    applyStimulus(32'h000, 1'b0, 32'h0);
    checkOutput("oor_no_alias", mem_data_out, 32'h2233_44A3);
    checkOutput("oor_sticky", {31'b0, oor_err}, 32'h1);
    applyStimulus(32'h8000_0010, 1'b0, 32'h0);
    checkOutput("oor_rd_data", mem_data_out, 32'h0);

    pulseReset();
    checkOutput("rst2_oor", {31'b0, oor_err}, 32'h0);
    applyStimulus(32'h20, 1'b0, 32'h0);
    checkOutput("rst2_storage", mem_data_out, 32'h0102_0304);

    applyStimulus(32'hFFFF_FFF0, 1'b1, 32'h7856_3412);
`ifdef DMEM_MMIO_EN
    checkOutput("mmio_reg", mmio_out, 32'h1234_5678);
    checkOutput("mmio_oor", {31'b0, oor_err}, 32'h0);
    checkOutput("mmio_count", {16'b0, wr_count}, 32'd1);
    checkOutput("mmio_fwd", mem_data_out, 32'h7856_3412);
    applyStimulus(32'hFFFF_FFF0, 1'b0, 32'h0);
    checkOutput("mmio_rd", mem_data_out, 32'h7856_3412);
`else
    checkOutput("nommio_oor", {31'b0, oor_err}, 32'h1);
    checkOutput("nommio_count", {16'b0, wr_count}, 32'h0);
    checkOutput("nommio_data", mem_data_out, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Byte-addressed data memory on the responder side of the processor's execute-stage memory interface.
- Accepts a 32-bit byte address, a write enable and four byte lanes from the initiator. Returns four byte lanes at that address with one-cycle registered read latency.
- Little-endian: lane i maps to byte address addr+i.
- Sits beside the instruction path. Its lane outputs feed the execute stage's load/store merge logic.

Parameters:
- AW, 10, byte-address width of the storage; DEPTH = 2**AW bytes.
- MMIO_ADDR, 32'hFFFF_FFF0, word address of the optional output register; used only with DMEM_MMIO_EN.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst_b  input  1  reset, asynchronous and active-low.
- mem_addr  input  32  byte address of the access.
- mem_write_en  input  1  1 = write the four lanes this cycle.
- mem_data_in  input  8 x [0:3]  write byte lanes; lane i targets addr+i.
- mem_data_out  output  8 x [0:3]  registered read byte lanes; lane i reads addr+i.
- oor_err  output  1  sticky out-of-range flag.
- wr_count  output  16  count of committed writes, wraps at 16'hFFFF -> 0.
- mmio_out  output  32  output register; present only with DMEM_MMIO_EN.

Behaviour:
- Reset (rst_b low, asynchronous):
  - mem_data_out lanes = 8'h00, oor_err = 0, wr_count = 0, mmio_out = 0.
  - Storage contents are NOT cleared.
  - Reset asserted mid-access aborts that access: no byte is written and no count is taken.
- In-range test: mem_addr[31:AW] == 0. Byte index for lane i = (mem_addr[AW-1:0] + i) mod DEPTH.
- Wrap-around: an access at DEPTH-1..DEPTH-3 wraps its upper lanes to index 0, 1, 2. This is not an error.
- Write, in range:
  - At posedge with mem_write_en=1, all four lanes are written.
  - Partial stores are handled by the initiator, which re-supplies old bytes; this block always writes 4 bytes.
  - wr_count increments by 1.
- Read, every cycle regardless of mem_write_en:
  - At each posedge, mem_data_out[i] <= byte at lane-i index of the mem_addr presented in that cycle.
  - Latency is exactly 1 cycle; no handshake; a new address is accepted every cycle.
- Same-cycle write and read of overlapping bytes is write-first: mem_data_out returns the new mem_data_in lane values for the written bytes, stored values for the others.
- Out of range (mem_addr[31:AW] != 0, excluding the MMIO word when enabled):
  - Write suppressed; wr_count unchanged.
  - mem_data_out lanes <= 8'h00.
  - oor_err <= 1; stays set until reset.
- Combinational arithmetic: lane index additions are AW bits wide, carry discarded.

Optional Feature:
- Macro: DMEM_MMIO_EN.
- With DMEM_MMIO_EN defined:
  - mem_addr == MMIO_ADDR with mem_write_en=1 sets mmio_out <= {lane3, lane2, lane1, lane0}.
  - Storage is not written; wr_count increments; oor_err is not set.
  - A read of MMIO_ADDR returns the mmio_out bytes on the lanes next cycle. Write-first applies.
- Without DMEM_MMIO_EN:
  - The mmio_out port and its register are absent.
  - MMIO_ADDR is treated as an ordinary out-of-range address.

Test Plan:
- Reset mid-write: drive mem_write_en=1, addr 0x10, then pull rst_b low before the edge -> mem_data_out all 00, oor_err 0, wr_count 0; byte 0x10 unchanged on later read.
- Write lanes {EF,BE,AD,DE} at 0x10, then read 0x10 -> one cycle later mem_data_out = {EF,BE,AD,DE}; wr_count = 1.
- Same-cycle write {01,02,03,04} at 0x20 with old contents {AA,AA,AA,AA} -> next cycle mem_data_out = {01,02,03,04}.
- Wrap, AW=10: write {11,22,33,44} at 0x3FF, read 0x000 -> {22,33,44,<old byte 0x003>}; read 0x3FF -> {11,22,33,44}; oor_err 0.
- Out of range: write {55,66,77,88} at 0x0000_0400 -> mem_data_out = 00s next cycle, oor_err = 1 and held over later in-range accesses, wr_count unchanged.
- DMEM_MMIO_EN: write {78,56,34,12} at 0xFFFF_FFF0 -> mmio_out = 32'h1234_5678, oor_err 0, wr_count +1. Without the macro, the same access -> oor_err = 1.
